seq_divider: RTL

// - Multi-cycle restoring divider for the MIPS multiply/divide unit (DIV/DIVU into HI/LO).
// - Inverse of the ripple adder datapath: produces quotient/remainder by repeated trial subtraction.
// - Resolves one quotient bit per clock. The EX stage issues start and stalls on busy.

---
 rtl/seq_divider.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider (DIV/DIVU) for the MIPS mult/div unit.
// One quotient bit per clock; signed ops run on magnitudes and fix signs at the end.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic             ge;

    // A new op is taken only while not busy (IDLE, or DONE for back-to-back).
    assign accept = start && (state_q == IDLE || state_q == DONE);

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dmag_q      <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dmag_q      <= dmag_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Next-state: zero divisor skips straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) state_d = (divisor == '0) ? DONE : RUN;
                else        state_d = IDLE;
            end
            RUN:     if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the state register only, so nothing combinational from inputs.
    always_comb begin
        busy        = (state_q == RUN) || (state_q == FIX);
        done        = (state_q == DONE);
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
    end

    // Datapath: operand capture, one shift/trial-subtract per RUN cycle, sign fix in FIX.
    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dmag_d      = dmag_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        sgn_a = signed_op & dividend[WIDTH-1];
        sgn_b = signed_op & divisor[WIDTH-1];
        a_mag = sgn_a ? -dividend : dividend;
        b_mag = sgn_b ? -divisor  : divisor;

        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dmag_q};
        // rem_q stays below the divisor, so its top bit is clear; if it were set the
        // true shifted value would exceed any divisor and the subtraction would succeed.
        ge      = rem_q[WIDTH] | ~trial[WIDTH];

        case (state_q)
            IDLE, DONE: begin
                if (accept && divisor != '0) begin
                    rem_d  = '0;
                    quo_d  = a_mag;
                    dmag_d = b_mag;
                    negq_d = sgn_a ^ sgn_b;
                    negr_d = sgn_a;
                    cnt_d  = CW'(WIDTH - 1);
                end else if (accept) begin
                    quotient_d  = '1;
                    remainder_d = dividend;
                    dbz_d       = 1'b1;
                end
            end
            RUN: begin
                rem_d = ge ? trial : shifted;
                quo_d = {quo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q - CW'(1);
            end
            FIX: begin
                quotient_d  = negq_q ? -quo_q : quo_q;
                remainder_d = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                dbz_d       = 1'b0;
            end
            default: ;
        endcase
    end
endmodule
